mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 156 +++++++++++++++
 tb/tb_mul_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Sequential radix-4 Booth mantissa multiplier.
// One Booth group of the multiplier is accumulated per clock cycle. Operands
// come in through a valid/ready handshake and the product goes out through
// another. A flush aborts the operation in flight without producing a result.
module mul_sequencer #(
    parameter int unsigned C_MANT = 23
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Valid_SI,
    output logic                  Ready_SO,
    input  logic [C_MANT:0]       Mant_a_DI,
    input  logic [C_MANT:0]       Mant_b_DI,
    input  logic                  Flush_SI,
    output logic                  Valid_SO,
    input  logic                  Ready_SI,
    output logic [2*C_MANT+1:0]   Prod_DO,
    output logic                  Busy_SO,
    output logic [3:0]            Grp_idx_DO
);

    localparam int unsigned C_NGRP  = (C_MANT + 1) / 2 + 1;
    localparam int unsigned C_ACCW  = 2 * C_MANT + 5;
    localparam int unsigned C_VECW  = C_MANT + 4;
    localparam int unsigned C_PRODW = 2 * C_MANT + 2;
    localparam logic [3:0]  C_LAST  = 4'(C_NGRP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [C_ACCW-1:0]    a_sh_q;    // multiplicand, pre-shifted by 2k for group k
    logic [C_VECW-1:0]    vec_q;     // recoding vector, shifted right by 2 per group
    logic [C_ACCW-1:0]    acc_q;
    logic [C_PRODW-1:0]   prod_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 busy_q;
    logic [3:0]           grp_q;

    logic [C_ACCW-1:0]    term_d;
    logic [C_ACCW-1:0]    acc_d;

    // Selects the Booth multiple (0, +-m, +-2m) of m for one 3-bit group.
    function automatic logic [C_ACCW-1:0] booth_term(input logic [2:0] grp,
                                                     input logic [C_ACCW-1:0] m);
        logic [C_ACCW-1:0] m2;
        logic [C_ACCW-1:0] t;
        m2 = {m[C_ACCW-2:0], 1'b0};
        case (grp)
            3'b001, 3'b010: t = m;
            3'b011:         t = m2;
            3'b100:         t = -m2;
            3'b101, 3'b110: t = -m;
            default:        t = {C_ACCW{1'b0}};
        endcase
        return t;
    endfunction

    // The lowest three bits of the shifting recoding vector always hold the current group,
    // and the shifting multiplicand already carries the 2k weight.
    assign term_d = booth_term(vec_q[2:0], a_sh_q);
    assign acc_d  = acc_q + term_d;

    // Control FSM with datapath registers and registered handshake/debug outputs.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_sh_q  <= {C_ACCW{1'b0}};
            vec_q   <= {C_VECW{1'b0}};
            acc_q   <= {C_ACCW{1'b0}};
            prod_q  <= {C_PRODW{1'b0}};
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            grp_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A flush in the same cycle vetoes the capture.
                    if (Valid_SI && !Flush_SI) begin
                        state_q <= RUN;
                        cnt_q   <= 4'd0;
                        a_sh_q  <= {{(C_ACCW - C_MANT - 1){1'b0}}, Mant_a_DI};
                        vec_q   <= {2'b00, Mant_b_DI, 1'b0};
                        acc_q   <= {C_ACCW{1'b0}};
                        ready_q <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        grp_q   <= 4'd0;
                    end else begin
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        grp_q   <= 4'd0;
                    end
                end
                RUN: begin
                    if (Flush_SI) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        grp_q   <= 4'd0;
                    end else if (cnt_q == C_LAST) begin
                        // The top group is always non-negative, so the final sum fits the product width.
                        state_q <= DONE;
                        cnt_q   <= 4'd0;
                        acc_q   <= acc_d;
                        prod_q  <= acc_d[C_PRODW-1:0];
                        valid_q <= 1'b1;
                        grp_q   <= 4'd0;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                        acc_q   <= acc_d;
                        a_sh_q  <= {a_sh_q[C_ACCW-3:0], 2'b00};
                        vec_q   <= {2'b00, vec_q[C_VECW-1:2]};
                        grp_q   <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    // Flush together with Ready counts as a normal consume; either way no new result.
                    if (Flush_SI || Ready_SI) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    grp_q   <= 4'd0;
                end
            endcase
        end
    end

    assign Ready_SO   = ready_q;
    assign Valid_SO   = valid_q;
    assign Busy_SO    = busy_q;
    assign Grp_idx_DO = grp_q;
    assign Prod_DO    = prod_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer (default 24-bit mantissas).
module tb_mul_sequencer;

    logic        clk_s = 1'b0;
    logic        rst_s = 1'b1;
    logic        valid_i_s = 1'b0;
    logic        ready_o_s;
    logic [23:0] a_s = 24'd0;
    logic [23:0] b_s = 24'd0;
    logic        flush_s = 1'b0;
    logic        valid_o_s;
    logic        ready_i_s = 1'b0;
    logic [47:0] prod_s;
    logic        busy_s;
    logic [3:0]  grp_s;

    int n_total = 0;
    int n_bad   = 0;

    mul_sequencer dut (
        .Clk_CI     (clk_s),
        .Rst_RI     (rst_s),
        .Valid_SI   (valid_i_s),
        .Ready_SO   (ready_o_s),
        .Mant_a_DI  (a_s),
        .Mant_b_DI  (b_s),
        .Flush_SI   (flush_s),
        .Valid_SO   (valid_o_s),
        .Ready_SI   (ready_i_s),
        .Prod_DO    (prod_s),
        .Busy_SO    (busy_s),
        .Grp_idx_DO (grp_s)
    );

    always #5 clk_s = ~clk_s;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_ready"}, 64'(ready_o_s), 64'd1);
        check_val({tag, "_valid"}, 64'(valid_o_s), 64'd0);
        check_val({tag, "_busy"},  64'(busy_s),    64'd0);
        check_val({tag, "_grp"},   64'(grp_s),     64'd0);
        check_val({tag, "_prod"},  64'(prod_s),    64'd0);
    endtask

    // Hand over one operand pair and wait (bounded) for the result.
    // lat counts cycles from the handshake cycle to the first Valid_SO cycle.
    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic rdy,
                          input bit chk_grp, output logic [47:0] prod, output int lat);
        a_s       = a;
        b_s       = b;
        ready_i_s = rdy;
        valid_i_s = 1'b1;
        tick();
        valid_i_s = 1'b0;
        lat = 1;
        while (!valid_o_s && lat < 40) begin
            if (chk_grp) check_val("grp_idx", 64'(grp_s), 64'(lat - 1));
            tick();
            lat++;
        end
        prod = prod_s;
    endtask

    initial begin
        logic [47:0] p;
        logic [47:0] exp_p;
        logic [23:0] ra;
        logic [23:0] rb;
        int          lat;
        int          n;
        int          seen;

        // Reset
        rst_s = 1'b1;
        tick();
        tick();
        check_reset_outs("reset");
        rst_s = 1'b0;
        tick();
        check_val("idle_ready", 64'(ready_o_s), 64'd1);

        // Full-scale operands, latency, one-cycle valid, group index trace
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, p, lat);
        check_val("max_lat",  64'(lat), 64'd14);
        check_val("max_prod", 64'(p), 64'hFFFFFE000001);
        check_val("max_ready_while_done", 64'(ready_o_s), 64'd0);
        check_val("max_busy_while_done", 64'(busy_s), 64'd1);
        tick();
        check_val("max_valid_one_cycle", 64'(valid_o_s), 64'd0);
        check_val("max_ready_after", 64'(ready_o_s), 64'd1);
        check_val("max_prod_hold", 64'(prod_s), 64'hFFFFFE000001);

        run_op(24'h800000, 24'h800000, 1'b1, 1'b0, p, lat);
        check_val("msb_prod", 64'(p), 64'h400000000000);
        tick();
        run_op(24'h123456, 24'h000000, 1'b1, 1'b0, p, lat);
        check_val("zero_prod", 64'(p), 64'h0);
        tick();
        run_op(24'h000001, 24'hFFFFFF, 1'b1, 1'b0, p, lat);
        check_val("one_prod", 64'(p), 64'hFFFFFF);
        tick();
        run_op(24'hAAAAAA, 24'h555555, 1'b1, 1'b0, p, lat);
        check_val("alt_prod", 64'(p), 64'h38E38DC71C72);
        tick();

        // Backpressure
        run_op(24'd7, 24'd9, 1'b0, 1'b0, p, lat);
        check_val("bp_lat", 64'(lat), 64'd14);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_valid_held", 64'(valid_o_s), 64'd1);
            check_val("bp_prod_stable", 64'(prod_s), 64'd63);
            check_val("bp_ready_low", 64'(ready_o_s), 64'd0);
        end
        ready_i_s = 1'b1;
        tick();
        check_val("bp_release_valid", 64'(valid_o_s), 64'd0);
        check_val("bp_release_ready", 64'(ready_o_s), 64'd1);
        check_val("bp_release_busy",  64'(busy_s), 64'd0);

        // Flush together with Valid in IDLE is not a handshake
        a_s = 24'd2;
        b_s = 24'd2;
        valid_i_s = 1'b1;
        flush_s   = 1'b1;
        tick();
        valid_i_s = 1'b0;
        flush_s   = 1'b0;
        check_val("idle_flush_ready", 64'(ready_o_s), 64'd1);
        check_val("idle_flush_busy",  64'(busy_s), 64'd0);

        // Flush in RUN at group 6
        a_s = 24'hFFFFFF;
        b_s = 24'h001234;
        valid_i_s = 1'b1;
        tick();
        valid_i_s = 1'b0;
        n = 0;
        while (grp_s != 4'd6 && n < 30) begin
            tick();
            n++;
        end
        check_val("flush_at_grp6", 64'(grp_s), 64'd6);
        flush_s = 1'b1;
        tick();
        flush_s = 1'b0;
        check_val("flush_ready", 64'(ready_o_s), 64'd1);
        check_val("flush_busy",  64'(busy_s), 64'd0);
        check_val("flush_grp",   64'(grp_s), 64'd0);
        check_val("flush_prod_kept", 64'(prod_s), 64'd63);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o_s) seen++;
            tick();
        end
        check_val("flush_no_result", 64'(seen), 64'd0);
        run_op(24'd3, 24'd5, 1'b1, 1'b0, p, lat);
        check_val("after_flush_prod", 64'(p), 64'd15);
        tick();

        // Flush in DONE keeps the loaded result
        run_op(24'h000100, 24'h000100, 1'b0, 1'b0, p, lat);
        check_val("done_flush_prod", 64'(p), 64'h10000);
        flush_s = 1'b1;
        tick();
        flush_s = 1'b0;
        check_val("done_flush_valid", 64'(valid_o_s), 64'd0);
        check_val("done_flush_ready", 64'(ready_o_s), 64'd1);
        check_val("done_flush_prod_kept", 64'(prod_s), 64'h10000);

        // Reset mid-RUN
        a_s = 24'hFFFFFF;
        b_s = 24'hFFFFFF;
        valid_i_s = 1'b1;
        tick();
        valid_i_s = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_s = 1'b1;
        flush_s = 1'b1;
        ready_i_s = 1'b1;
        tick();
        rst_s = 1'b0;
        flush_s = 1'b0;
        check_reset_outs("rst_run");

        // Reset in DONE
        run_op(24'h000003, 24'h000003, 1'b0, 1'b0, p, lat);
        check_val("pre_rst_done_prod", 64'(p), 64'd9);
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        check_reset_outs("rst_done");
        run_op(24'hABCDEF, 24'h000001, 1'b1, 1'b0, p, lat);
        check_val("after_rst_prod", 64'(p), 64'hABCDEF);
        tick();

        // Pseudo-random operands with random gaps and backpressure
        for (int k = 0; k < 300; k++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            exp_p = {24'd0, ra} * {24'd0, rb};
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) tick();
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, p, lat);
            check_val("rand_prod", 64'(p), 64'(exp_p));
            check_val("rand_lat", 64'(lat), 64'd14);
            if (!ready_i_s) begin
                n = $urandom_range(1, 3);
                for (int g = 0; g < n; g++) tick();
                ready_i_s = 1'b1;
            end
            tick();
            check_val("rand_single_result", 64'(valid_o_s), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
